// File: rtl/pointwise_sub_seq_pkg.sv
// Shared vector-unit types and constants for the element-wise subtractor.
// MAX_NEURONS may be supplied as a macro; it defaults to 8 lanes.
`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

package pointwise_sub_seq_pkg;

  localparam int MAX_NEURONS = `MAX_NEURONS;
  localparam int WIDTH       = 32;
  localparam int FRAC        = 16;
  localparam int IDX_W       = $clog2(MAX_NEURONS + 1);

  typedef logic [MAX_NEURONS-1:0][WIDTH-1:0] arr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

endpackage

// File: rtl/pointwise_sub_seq_qsub.sv
// Combinational two's-complement subtract c = a - b with overflow flag.
// POINTWISE_SUB_SATURATE_EN clamps overflowing results instead of wrapping.
module qsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    ovf  = diff[WIDTH] ^ diff[WIDTH-1];
    c    = diff[WIDTH-1:0];
`ifdef POINTWISE_SUB_SATURATE_EN
    // Sign of the wide difference picks the rail to clamp to.
    if (ovf) begin
      c = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/pointwise_sub_seq.sv
// Sequential out[i] = vector1[i] - vector2[i], one lane per clock.
// Saturation is enabled with the POINTWISE_SUB_SATURATE_EN macro.
module pointwise_sub_seq #(
  parameter int MAX_NEURONS = pointwise_sub_seq_pkg::MAX_NEURONS,
  parameter int WIDTH       = pointwise_sub_seq_pkg::WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(MAX_NEURONS+1)-1:0]    length,
  input  logic [MAX_NEURONS-1:0][WIDTH-1:0]   vector1,
  input  logic [MAX_NEURONS-1:0][WIDTH-1:0]   vector2,
  output logic [MAX_NEURONS-1:0][WIDTH-1:0]   out,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow
);

  import pointwise_sub_seq_pkg::*;

  localparam int IW = $clog2(MAX_NEURONS + 1);

  sub_state_t        state;
  sub_state_t        state_nxt;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     len;
  logic [IW-1:0]     len_eff;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  res;
  logic              lane_ovf;
  logic              accept;

  always_comb begin
    len_eff = length;
    if (length > IW'(MAX_NEURONS))
      len_eff = IW'(MAX_NEURONS);
  end

  assign accept = start && (state != RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nxt = (len_eff == '0) ? DONE : RUN;
        else
          state_nxt = IDLE;
      end
      RUN: begin
        if (idx == len - 1'b1)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane select as a compare loop so an out-of-range idx reads zero.
  always_comb begin
    opa = '0;
    opb = '0;
    for (int i = 0; i < MAX_NEURONS; i++) begin
      if (idx == IW'(i)) begin
        opa = vector1[i];
        opb = vector2[i];
      end
    end
  end

  qsub #(
    .WIDTH (WIDTH)
  ) u_qsub (
    .a   (opa),
    .b   (opb),
    .c   (res),
    .ovf (lane_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        len      <= len_eff;
        idx      <= '0;
        out      <= '0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        for (int i = 0; i < MAX_NEURONS; i++) begin
          if (idx == IW'(i))
            out[i] <= res;
        end
        idx <= idx + 1'b1;
        if (lane_ovf)
          overflow <= 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pointwise_sub_seq.sv
// Randomized self-checking bench for pointwise_sub_seq.
// Reference model uses 64-bit integer arithmetic per lane.
module tb_pointwise_sub_seq;

  import pointwise_sub_seq_pkg::*;

  localparam int N  = MAX_NEURONS;
  localparam int IW = IDX_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] length;
  arr_t          vector1;
  arr_t          vector2;
  arr_t          out;
  logic          busy;
  logic          done;
  logic          overflow;

  always #5 clk = ~clk;

  pointwise_sub_seq #(
    .MAX_NEURONS (N),
    .WIDTH       (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .vector1  (vector1),
    .vector2  (vector2),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  arr_t exp_out;
  logic exp_ovf;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          output logic o);
    longint d;
    longint lim;
    lim = 64'sh7fffffff;
    d   = longint'($signed(a)) - longint'($signed(b));
    o   = (d > lim) || (d < -lim - 1);
`ifdef POINTWISE_SUB_SATURATE_EN
    if (d > lim)
      return 32'h7fffffff;
    if (d < -lim - 1)
      return 32'h80000000;
`endif
    return d[31:0];
  endfunction

  task automatic build_expect(input int len_in);
    int   leff;
    logic o;
    leff    = (len_in > N) ? N : len_in;
    exp_out = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < leff; i++) begin
      exp_out[i] = ref_sub(vector1[i], vector2[i], o);
      exp_ovf    = exp_ovf | o;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h7fffffff;
      1:       return 32'h80000000;
      2:       return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_vecs();
    for (int i = 0; i < N; i++) begin
      vector1[i] = pick();
      vector2[i] = pick();
    end
  endtask

  task automatic run_op(input int len_in, input bit b2b,
                        input bit mid, input string tag);
    int leff;
    int cycles;
    int busy_cnt;
    leff = (len_in > N) ? N : len_in;
    if (!b2b)
      @(negedge clk);
    length = IW'(len_in);
    start  = 1'b1;
    build_expect(len_in);
    @(negedge clk);
    start    = 1'b0;
    cycles   = 1;
    busy_cnt = 0;
    check({tag, ".clr"}, 64'(|out), 64'd0);
    while (!done && cycles < 200) begin
      if (busy)
        busy_cnt++;
      start = mid && (cycles == 1);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".lat"}, cycles, leff + 1);
    check({tag, ".busycnt"}, busy_cnt, leff);
    check({tag, ".busy@done"}, 64'(busy), 64'd0);
    check({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
    for (int i = 0; i < N; i++)
      check($sformatf("%s.lane%0d", tag, i), out[i], exp_out[i]);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    length  = '0;
    vector1 = '0;
    vector2 = '0;
    repeat (3) @(negedge clk);
    check("rst.out", 64'(|out), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    reset = 1'b0;

    rand_vecs();
    vector1[0] = 32'h00030000;
    vector2[0] = 32'h00018000;
    vector1[1] = 32'h00000000;
    vector2[1] = 32'h00004000;
    run_op(2, 1'b0, 1'b0, "basic");
    check("basic.c0", out[0], 64'h00018000);
    check("basic.c1", out[1], 64'hFFFFC000);
    check("basic.ovfc", 64'(overflow), 64'd0);
    @(negedge clk);
    check("hold.c0", out[0], 64'h00018000);
    check("hold.done", 64'(done), 64'd0);

    rand_vecs();
    vector1[0] = 32'h7FFF0000;
    vector2[0] = 32'hFFFF0000;
    run_op(1, 1'b0, 1'b0, "ovf");
`ifdef POINTWISE_SUB_SATURATE_EN
    check("ovf.c0", out[0], 64'h7FFFFFFF);
`else
    check("ovf.c0", out[0], 64'h80000000);
`endif
    check("ovf.flag", 64'(overflow), 64'd1);

    rand_vecs();
    run_op(0, 1'b0, 1'b0, "len0");
    rand_vecs();
    run_op(N + 5, 1'b0, 1'b0, "lenmax");
    rand_vecs();
    run_op(5, 1'b0, 1'b1, "mid");
    rand_vecs();
    run_op(3, 1'b0, 1'b0, "b2b1");
    rand_vecs();
    run_op(4, 1'b1, 1'b0, "b2b2");

    rand_vecs();
    @(negedge clk);
    length = IW'(4);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.out", 64'(|out), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    run_op(4, 1'b0, 1'b0, "after");

    for (int k = 0; k < 30; k++) begin
      rand_vecs();
      run_op($urandom_range(0, N + 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pointwise_sub_seq.md
# pointwise_sub_seq

Sequential element-wise fixed-point subtractor for the backward (error/gradient) path of the feed-forward accelerator. It computes out[i] = vector1[i] − vector2[i], for example target minus activation, over the first `length` lanes of an `ARR` vector. It uses one shared subtractor and produces one element per clock. A start/busy/done handshake lets the training controller sequence it with the other vector units.

## Interface
- Parameters (defaults come from the shared package)
  - `MAX_NEURONS`, `MAX_NEURONS` macro: lanes per `ARR`.
  - `WIDTH`, 32: element width, two's complement.
  - `FRAC`, 16: fractional bits (Q16.16). It has no effect on subtraction; it is kept for format consistency.
- Ports (clock and reset first)
  - `clk`, in, 1: single clock. All logic is rising-edge.
  - `reset`, in, 1: synchronous, active-high.
  - `start`, in, 1: one-cycle request to begin an operation.
  - `length`, in, `$clog2(MAX_NEURONS+1)`: number of lanes to process. It is sampled at start.
  - `vector1`, in, `ARR`: minuend. Must be held stable while `busy`.
  - `vector2`, in, `ARR`: subtrahend. Must be held stable while `busy`.
  - `out`, out, `ARR`: registered result vector.
  - `busy`, out, 1: operation in progress.
  - `done`, out, 1: one-cycle completion pulse.
  - `overflow`, out, 1: sticky per-operation overflow flag.

## Operation
- Reset values: FSM = `IDLE`, index = 0, `out` = all zeros, `busy` = 0, `done` = 0, `overflow` = 0.
- FSM states and transitions:
  - `IDLE`: `start` → `RUN`.
  - `RUN`: after the element at index L−1 is written → `DONE`.
  - `DONE`: lasts one cycle. `start` → `RUN`; otherwise → `IDLE`.
- Accepting `start` (in `IDLE` or `DONE`):
  - latch L = min(`length`, `MAX_NEURONS`);
  - clear all `out` lanes to 0;
  - clear `overflow`;
  - set index = 0.
- `start` while in `RUN` is ignored and has no side effects.
- `RUN`: on each edge, out[index] ← vector1[index] − vector2[index], then index increments.
- Lanes at index ≥ L stay 0.
- L = 0: go straight from start acceptance to `DONE`; `out` is all zeros.
- Arithmetic:
  - full WIDTH+1-bit difference;
  - overflow = the top two bits of the difference differ;
  - result handling is set by the macro in Configuration.
- `out` holds its value after `DONE` until the next accepted `start` or `reset`.
- `reset` during `RUN` aborts immediately and restores all reset values. No `done` is issued.

## Timing
- Let E0 be the edge that accepts `start`.
- `busy` = 1 from E0 until edge E_L.
- Element i is written at edge E(i+1).
- `done` = 1 for exactly the cycle after E_L, with `busy` = 0 in that cycle.
- Latency from start to done is L+1 cycles; throughput is 1 element per cycle.
- L = 0: `done` is high in the cycle after E0 and `busy` never rises.
- Back-to-back operation: `start` asserted in the `done` cycle re-enters `RUN` at the next edge with no idle gap.
- `overflow` is valid and stable whenever `done` = 1.

## Configuration
- Macro: `POINTWISE_SUB_SATURATE_EN`.
- Defined:
  - an overflowing lane clamps to 0x7FFF…F (positive overflow) or 0x800…0 (negative overflow);
  - `overflow` is set sticky for the operation.
- Undefined:
  - results wrap to the low WIDTH bits;
  - `overflow` is still computed and reported.

## Structure
- Shared package (same home as `ARR`, `MAX_NEURONS`):
  - `WIDTH` and `FRAC`;
  - the FSM state enum `sub_state_t` {`IDLE`, `RUN`, `DONE`};
  - length/index width constant `IDX_W = $clog2(MAX_NEURONS+1)`.
- One sub-module, `qsub`:
  - combinational;
  - a, b → c plus ovf;
  - contains the saturation logic under the macro;
  - the counterpart of `qadd`, reusable elsewhere.
- Sequencing, index counter and output registers live in the top module.

## Test plan
- Basic subtraction, Q16.16:
  - stimulus: L = 2; lane 0 = 3.0 − 1.5 (0x00030000 − 0x00018000); lane 1 = 0 − 0.25 (0 − 0x00004000);
  - response: out[0] = 0x00018000, out[1] = 0xFFFFC000, all other lanes 0;
  - `done` arrives exactly 3 cycles after start; `overflow` = 0.
- Overflow:
  - stimulus: lane 0 = 0x7FFF0000 − 0xFFFF0000;
  - with the macro: 0x7FFFFFFF and `overflow` = 1;
  - without the macro: 0x80000000 and `overflow` = 1.
- Boundaries:
  - L = 0 → `done` in the next cycle, `out` all zeros, `busy` never high;
  - `length` = `MAX_NEURONS`+5 → exactly `MAX_NEURONS` lanes processed, `done` after `MAX_NEURONS`+1 cycles.
- Handshake:
  - `start` pulsed mid-`RUN` → ignored, results unchanged;
  - `start` in the `done` cycle → second operation runs with no gap, and `out` is cleared at its acceptance edge.
- Reset mid-operation:
  - stimulus: assert `reset` at edge E2 of an L = 4 run;
  - response: next cycle `out` = 0, `busy` = 0, `done` = 0, `overflow` = 0; a new start then completes normally.
